dma_burst_sched: RTL and testbench
==================================

Name: dma_burst_sched

Overview:
- Consumes one command from the AXI-lite config register block (CONFIG_VALID/READY, CMD, SRC, DEST, LEN) and turns it into a stream of matched read and write burst requests for the memory-copy datapath.
- Splits each transfer at MAX_BURST beats and at 4 KB boundaries, and bounds the number of outstanding write bursts.
- Holds CONFIG_READY low until every write burst has completed. This drives the config block's cycle counter and IRQ.

Parameters:
- BEAT_BYTES, 8, bytes per data beat (power of 2).
- MAX_BURST, 16, maximum beats per burst (power of 2, ≤256).
- MAX_OUTST, 8, maximum write bursts issued but not yet completed.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- CONFIG_VALID  in  1  command valid.
- CONFIG_READY  out  1  high only in IDLE; accept occurs on VALID&&READY.
- CONFIG_CMD  in  32  bit0 = copy enable; other bits ignored.
- CONFIG_SRC  in  32  source byte address.
- CONFIG_DEST  in  32  destination byte address.
- CONFIG_LEN  in  32  length in bytes.
- RD_REQ_VALID  out  1  read burst request valid.
- RD_REQ_READY  in  1  read request accept.
- RD_REQ_ADDR  out  32  read burst address.
- RD_REQ_LEN  out  8  read burst beats minus 1.
- WR_REQ_VALID  out  1  write burst request valid.
- WR_REQ_READY  in  1  write request accept.
- WR_REQ_ADDR  out  32  write burst address.
- WR_REQ_LEN  out  8  write burst beats minus 1.
- WR_DONE  in  1  one-cycle pulse per completed write burst.
- WR_RESP  in  2  write response, sampled with WR_DONE.
- STATUS_ERR  out  1  sticky error; cleared on the next accept.

Behaviour:
- Reset (async, ARESETN=0): state=IDLE, CONFIG_READY=1, RD/WR_REQ_VALID=0, REQ_ADDR/LEN=0, outstanding=0, STATUS_ERR=0.
- States: IDLE, CALC, ISSUE, DRAIN, FINISH.
- IDLE: on accept, latch the following and go to CALC:
  - src and dest with low log2(BEAT_BYTES) bits forced to 0;
  - beats_rem = LEN / BEAT_BYTES (remainder bytes dropped);
  - STATUS_ERR cleared.
  - If CMD[0]=0 or beats_rem=0, go directly to FINISH instead.
- CALC (1 cycle): register the next burst size n = min(MAX_BURST, beats_rem, (4096 - src[11:0])/BEAT_BYTES, (4096 - dest[11:0])/BEAT_BYTES).
  - Drive REQ_ADDR = src/dest and REQ_LEN = n-1, then go to ISSUE.
- ISSUE:
  - RD_REQ_VALID asserts unconditionally.
  - WR_REQ_VALID asserts only while outstanding < MAX_OUTST.
  - Each channel handshakes independently; VALID drops after its own handshake, and ADDR/LEN stay stable while VALID is high.
  - When both channels are accepted: src += n*BEAT_BYTES, dest += n*BEAT_BYTES, beats_rem -= n. Go to CALC if beats_rem ≠ 0, else DRAIN.
- Outstanding counter, width clog2(MAX_OUTST+1):
  - +1 on WR_REQ handshake, -1 on WR_DONE; a simultaneous handshake and WR_DONE leaves it unchanged.
  - WR_DONE with outstanding=0 is ignored and sets STATUS_ERR.
  - WR_DONE with WR_RESP≠0 sets STATUS_ERR.
- DRAIN: wait for outstanding=0, then go to FINISH.
- FINISH (1 cycle, CONFIG_READY=0), then IDLE.
- Minimum latency for a non-empty command: accept → CONFIG_READY high again is ≥4 cycles.
- Addresses wrap modulo 2^32. A burst never crosses 4 KB on either side.
- CONFIG_VALID outside IDLE is ignored (not accepted).

Optional Feature:
- Macro: DMA_ABORT_EN. When defined, adds port ABORT (in, 1).
- ABORT high in CALC or ISSUE:
  - Any request already handshaken on a channel is kept; a channel not yet handshaken in the current burst drops VALID.
  - Go to DRAIN and set STATUS_ERR.
- ABORT in IDLE, DRAIN or FINISH has no effect.
- When undefined: no port, no logic.

Decomposition:
- Package dma_sched_pkg holds:
  - the state enum;
  - BOUNDARY_BYTES=4096;
  - the beats-to-boundary function;
  - the response code OKAY=2'b00.
- One sub-module, dma_burst_calc: registered computation of n from src, dest and beats_rem (the CALC stage).

Test Plan:
- SRC=0x1000, DEST=0x2000, LEN=256 (BEAT_BYTES=8) → two read/write pairs: addresses 0x1000/0x2000 then 0x1080/0x2080, LEN=15 each; CONFIG_READY returns high after the 2nd WR_DONE.
- SRC=0x0FF0, DEST=0x3000, LEN=64 → bursts with LEN=1 at 0x0FF0/0x3000, then LEN=5 at 0x1000/0x3010; no 4 KB crossing.
- LEN=0 or CMD=0 → exactly one FINISH cycle, no requests, STATUS_ERR=0.
- MAX_OUTST=8, LEN=2048, WR_DONE withheld → exactly 8 write handshakes, WR_REQ_VALID then held low; releasing one WR_DONE permits the 9th.
- WR_RESP=2'b10 on one WR_DONE → STATUS_ERR=1 after completion; cleared on the next accept.
- ARESETN pulled low mid-ISSUE with outstanding=3 → outputs immediately at reset values; after release, a new command runs normally.

Source files
------------

// File: rtl/dma_sched_pkg.sv
// Shared types and helpers for the DMA burst scheduler: FSM states, the 4 KB
// boundary size, the OKAY write response and the beats-to-boundary helper.
package dma_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_ISSUE,
      ST_DRAIN,
      ST_FINISH
   } state_t;

   localparam int BOUNDARY_BYTES = 4096;
   localparam logic [1:0] OKAY = 2'b00;

   // Beats left before the next 4 KB boundary, for a beat-aligned page offset.
   function automatic logic [12:0] beats_to_boundary(input logic [11:0] offset,
                                                     input int unsigned shift);
      logic [12:0] bytes_left;
      bytes_left = 13'(BOUNDARY_BYTES) - {1'b0, offset};
      return bytes_left >> shift;
   endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Burst-size stage: registers n = min(MAX_BURST, beats left, room to the 4 KB
// boundary on the source side, room on the destination side).
module dma_burst_calc
   import dma_sched_pkg::*;
#(
   parameter int BEAT_BYTES = 8,
   parameter int MAX_BURST  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [11:0] src_off,
   input  logic [11:0] dest_off,
   input  logic [31:0] beats_rem,
   output logic [8:0]  n,
   output logic [7:0]  len
);

   localparam int unsigned SHIFT = $clog2(BEAT_BYTES);

   logic [12:0] src_room;
   logic [12:0] dest_room;
   logic [8:0]  n_next;

   always_comb begin
      src_room  = beats_to_boundary(src_off, SHIFT);
      dest_room = beats_to_boundary(dest_off, SHIFT);
      n_next    = 9'(MAX_BURST);
      if (beats_rem < 32'(n_next))
         n_next = beats_rem[8:0];
      if (src_room < 13'(n_next))
         n_next = src_room[8:0];
      if (dest_room < 13'(n_next))
         n_next = dest_room[8:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n   <= '0;
         len <= '0;
      end else if (en) begin
         n   <= n_next;
         len <= 8'(n_next - 9'd1);
      end
   end

endmodule

// File: rtl/dma_burst_sched.sv
// DMA burst scheduler: splits one copy command into matched read/write bursts,
// bounded by MAX_BURST, 4 KB pages and MAX_OUTST outstanding writes.
// Optional macro DMA_ABORT_EN adds an ABORT input that stops issuing and drains.
module dma_burst_sched
   import dma_sched_pkg::*;
#(
   parameter int BEAT_BYTES = 8,
   parameter int MAX_BURST  = 16,
   parameter int MAX_OUTST  = 8
) (
   input  logic        ACLK,
   input  logic        ARESETN,
`ifdef DMA_ABORT_EN
   input  logic        ABORT,
`endif
   input  logic        CONFIG_VALID,
   output logic        CONFIG_READY,
   input  logic [31:0] CONFIG_CMD,
   input  logic [31:0] CONFIG_SRC,
   input  logic [31:0] CONFIG_DEST,
   input  logic [31:0] CONFIG_LEN,
   output logic        RD_REQ_VALID,
   input  logic        RD_REQ_READY,
   output logic [31:0] RD_REQ_ADDR,
   output logic [7:0]  RD_REQ_LEN,
   output logic        WR_REQ_VALID,
   input  logic        WR_REQ_READY,
   output logic [31:0] WR_REQ_ADDR,
   output logic [7:0]  WR_REQ_LEN,
   input  logic        WR_DONE,
   input  logic [1:0]  WR_RESP,
   output logic        STATUS_ERR
);

   localparam int unsigned SHIFT = $clog2(BEAT_BYTES);
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam logic [OW-1:0] OUTST_LIMIT = OW'(MAX_OUTST);

   state_t        state;
   logic [31:0]   src;
   logic [31:0]   dest;
   logic [31:0]   beats_rem;
   logic [OW-1:0] outst;
   logic [OW-1:0] outst_next;
   logic          rd_sent;
   logic          wr_sent;
   logic [8:0]    n;
   logic [31:0]   step;
   logic          rd_hs;
   logic          wr_hs;
   logic          done_ok;
   logic          stray_done;
   logic          bad_resp;
   logic          both_done;
   logic          abort_req;
   logic          unused_cmd_bits;

`ifdef DMA_ABORT_EN
   assign abort_req = ABORT;
`else
   assign abort_req = 1'b0;
`endif

   assign unused_cmd_bits = ^CONFIG_CMD[31:1];

   dma_burst_calc #(
      .BEAT_BYTES (BEAT_BYTES),
      .MAX_BURST  (MAX_BURST)
   ) u_calc (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .en        (state == ST_CALC),
      .src_off   (src[11:0]),
      .dest_off  (dest[11:0]),
      .beats_rem (beats_rem),
      .n         (n),
      .len       (RD_REQ_LEN)
   );

   assign WR_REQ_LEN = RD_REQ_LEN;

   // A handshake and a valid completion in the same cycle cancel out.
   always_comb begin
      rd_hs      = RD_REQ_VALID && RD_REQ_READY;
      wr_hs      = WR_REQ_VALID && WR_REQ_READY;
      done_ok    = WR_DONE && (outst != '0);
      stray_done = WR_DONE && (outst == '0);
      bad_resp   = WR_DONE && (WR_RESP != OKAY);
      both_done  = (rd_sent || rd_hs) && (wr_sent || wr_hs);
      step       = 32'(n) << SHIFT;
      outst_next = outst;
      if (wr_hs && !done_ok)
         outst_next = outst + OW'(1);
      else if (!wr_hs && done_ok)
         outst_next = outst - OW'(1);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state        <= ST_IDLE;
         CONFIG_READY <= 1'b1;
         RD_REQ_VALID <= 1'b0;
         WR_REQ_VALID <= 1'b0;
         RD_REQ_ADDR  <= '0;
         WR_REQ_ADDR  <= '0;
         src          <= '0;
         dest         <= '0;
         beats_rem    <= '0;
         outst        <= '0;
         rd_sent      <= 1'b0;
         wr_sent      <= 1'b0;
         STATUS_ERR   <= 1'b0;
      end else begin
         outst <= outst_next;
         if (rd_hs)
            RD_REQ_VALID <= 1'b0;
         if (wr_hs)
            WR_REQ_VALID <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (CONFIG_VALID) begin
                  src          <= CONFIG_SRC & ~32'(BEAT_BYTES - 1);
                  dest         <= CONFIG_DEST & ~32'(BEAT_BYTES - 1);
                  beats_rem    <= CONFIG_LEN >> SHIFT;
                  STATUS_ERR   <= 1'b0;
                  CONFIG_READY <= 1'b0;
                  if (CONFIG_CMD[0] && ((CONFIG_LEN >> SHIFT) != 32'd0))
                     state <= ST_CALC;
                  else
                     state <= ST_FINISH;
               end
            end

            ST_CALC: begin
               if (abort_req) begin
                  STATUS_ERR <= 1'b1;
                  state      <= ST_DRAIN;
               end else begin
                  RD_REQ_ADDR  <= src;
                  WR_REQ_ADDR  <= dest;
                  RD_REQ_VALID <= 1'b1;
                  WR_REQ_VALID <= (outst_next < OUTST_LIMIT);
                  rd_sent      <= 1'b0;
                  wr_sent      <= 1'b0;
                  state        <= ST_ISSUE;
               end
            end

            // Channels handshake independently; the burst advances once both have.
            ST_ISSUE: begin
               if (abort_req) begin
                  RD_REQ_VALID <= 1'b0;
                  WR_REQ_VALID <= 1'b0;
                  STATUS_ERR   <= 1'b1;
                  state        <= ST_DRAIN;
               end else begin
                  if (rd_hs)
                     rd_sent <= 1'b1;
                  if (wr_hs)
                     wr_sent <= 1'b1;
                  if (!WR_REQ_VALID && !wr_sent && (outst_next < OUTST_LIMIT))
                     WR_REQ_VALID <= 1'b1;
                  if (both_done) begin
                     src       <= src + step;
                     dest      <= dest + step;
                     beats_rem <= beats_rem - 32'(n);
                     state     <= (beats_rem == 32'(n)) ? ST_DRAIN : ST_CALC;
                  end
               end
            end

            ST_DRAIN: begin
               if (outst == '0)
                  state <= ST_FINISH;
            end

            ST_FINISH: begin
               CONFIG_READY <= 1'b1;
               state        <= ST_IDLE;
            end

            default: begin
               CONFIG_READY <= 1'b1;
               state        <= ST_IDLE;
            end
         endcase

         if (stray_done || bad_resp)
            STATUS_ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dma_burst_sched.sv
// Self-checking bench for dma_burst_sched: a model-fed scoreboard of expected
// read/write bursts, a table of commands, and hand sequences for the corner cases.
module tb_dma_burst_sched;

   localparam int BEAT_BYTES = 8;
   localparam int MAX_BURST  = 16;
   localparam int MAX_OUTST  = 8;

   logic        ACLK;
   logic        ARESETN;
   logic        abort;
   logic        CONFIG_VALID;
   logic        CONFIG_READY;
   logic [31:0] CONFIG_CMD;
   logic [31:0] CONFIG_SRC;
   logic [31:0] CONFIG_DEST;
   logic [31:0] CONFIG_LEN;
   logic        RD_REQ_VALID;
   logic        RD_REQ_READY;
   logic [31:0] RD_REQ_ADDR;
   logic [7:0]  RD_REQ_LEN;
   logic        WR_REQ_VALID;
   logic        WR_REQ_READY;
   logic [31:0] WR_REQ_ADDR;
   logic [7:0]  WR_REQ_LEN;
   logic        WR_DONE;
   logic [1:0]  WR_RESP;
   logic        STATUS_ERR;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } burst_t;

   typedef struct {
      logic [31:0] cmd;
      logic [31:0] src;
      logic [31:0] dest;
      logic [31:0] len;
      int          pairs;
   } vec_t;

   burst_t exp_rd_q[$];
   burst_t exp_wr_q[$];
   vec_t   vecs[8];

   int   checks = 0;
   int   errors = 0;
   int   rd_count = 0;
   int   wr_count = 0;
   int   done_count = 0;
   int   pending = 0;
   int   manual_req = 0;
   bit   auto_done = 1'b1;
   bit   bad_once = 1'b0;
   bit   rand_ready = 1'b0;
   logic rd_ready_cfg = 1'b1;
   logic wr_ready_cfg = 1'b1;
   logic err_at_accept;

   dma_burst_sched #(
      .BEAT_BYTES (BEAT_BYTES),
      .MAX_BURST  (MAX_BURST),
      .MAX_OUTST  (MAX_OUTST)
   ) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
`ifdef DMA_ABORT_EN
      .ABORT        (abort),
`endif
      .CONFIG_VALID (CONFIG_VALID),
      .CONFIG_READY (CONFIG_READY),
      .CONFIG_CMD   (CONFIG_CMD),
      .CONFIG_SRC   (CONFIG_SRC),
      .CONFIG_DEST  (CONFIG_DEST),
      .CONFIG_LEN   (CONFIG_LEN),
      .RD_REQ_VALID (RD_REQ_VALID),
      .RD_REQ_READY (RD_REQ_READY),
      .RD_REQ_ADDR  (RD_REQ_ADDR),
      .RD_REQ_LEN   (RD_REQ_LEN),
      .WR_REQ_VALID (WR_REQ_VALID),
      .WR_REQ_READY (WR_REQ_READY),
      .WR_REQ_ADDR  (WR_REQ_ADDR),
      .WR_REQ_LEN   (WR_REQ_LEN),
      .WR_DONE      (WR_DONE),
      .WR_RESP      (WR_RESP),
      .STATUS_ERR   (STATUS_ERR)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] crosses_4k(input logic [31:0] addr, input logic [7:0] len);
      int unsigned end_off;
      end_off = int'(addr & 32'hFFF) + (int'(len) + 1) * BEAT_BYTES;
      return (end_off > 4096) ? 32'd1 : 32'd0;
   endfunction

   task automatic push_pair(input logic [31:0] rd_addr, input logic [31:0] wr_addr, input logic [7:0] len);
      burst_t b;
      b.len  = len;
      b.addr = rd_addr;
      exp_rd_q.push_back(b);
      b.addr = wr_addr;
      exp_wr_q.push_back(b);
   endtask

   // Reference splitter: cap at MAX_BURST, beats left and both 4 KB pages.
   task automatic model_push(input logic [31:0] cmd, input logic [31:0] src,
                             input logic [31:0] dest, input logic [31:0] len);
      logic [31:0] s;
      logic [31:0] d;
      int unsigned rem;
      int unsigned nb;
      int unsigned room;
      if (!cmd[0])
         return;
      s   = src & ~32'(BEAT_BYTES - 1);
      d   = dest & ~32'(BEAT_BYTES - 1);
      rem = len / BEAT_BYTES;
      while (rem > 0) begin
         nb = MAX_BURST;
         if (rem < nb) nb = rem;
         room = (4096 - int'(s % 4096)) / BEAT_BYTES;
         if (room < nb) nb = room;
         room = (4096 - int'(d % 4096)) / BEAT_BYTES;
         if (room < nb) nb = room;
         push_pair(s, d, 8'(nb - 1));
         s   = s + 32'(nb * BEAT_BYTES);
         d   = d + 32'(nb * BEAT_BYTES);
         rem = rem - nb;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] cmd, input logic [31:0] src,
                                input logic [31:0] dest, input logic [31:0] len,
                                input bit use_model);
      int guard = 0;
      while (CONFIG_READY !== 1'b1 && guard < 2000) begin
         @(negedge ACLK);
         guard++;
      end
      checkOutput("ready_before_cmd", 32'(CONFIG_READY), 32'd1);
      @(posedge ACLK);
      #1;
      rd_count   = 0;
      wr_count   = 0;
      done_count = 0;
      if (use_model)
         model_push(cmd, src, dest, len);
      CONFIG_VALID = 1'b1;
      CONFIG_CMD   = cmd;
      CONFIG_SRC   = src;
      CONFIG_DEST  = dest;
      CONFIG_LEN   = len;
      @(posedge ACLK);
      #1;
      CONFIG_VALID  = 1'b0;
      err_at_accept = STATUS_ERR;
   endtask

   task automatic wait_done(input string name, input int exp_pairs, input logic exp_err,
                            input int min_low, input int max_low);
      int low = 0;
      @(negedge ACLK);
      while (CONFIG_READY !== 1'b1 && low < 5000) begin
         low++;
         @(negedge ACLK);
      end
      checkOutput({name, "_ready_back"}, 32'(CONFIG_READY), 32'd1);
      checkOutput({name, "_rd_bursts"}, 32'(rd_count), 32'(exp_pairs));
      checkOutput({name, "_wr_bursts"}, 32'(wr_count), 32'(exp_pairs));
      checkOutput({name, "_wr_dones"}, 32'(done_count), 32'(exp_pairs));
      checkOutput({name, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
      checkOutput({name, "_wr_left"}, 32'(exp_wr_q.size()), 32'd0);
      checkOutput({name, "_status_err"}, 32'(STATUS_ERR), 32'(exp_err));
      checkOutput({name, "_busy_cycles"}, 32'(low), (low >= min_low && low <= max_low) ? 32'(low) : 32'(min_low));
      exp_rd_q.delete();
      exp_wr_q.delete();
   endtask

   task automatic check_reset_state(input string name);
      checkOutput({name, "_config_ready"}, 32'(CONFIG_READY), 32'd1);
      checkOutput({name, "_rd_valid"}, 32'(RD_REQ_VALID), 32'd0);
      checkOutput({name, "_wr_valid"}, 32'(WR_REQ_VALID), 32'd0);
      checkOutput({name, "_rd_addr"}, RD_REQ_ADDR, 32'd0);
      checkOutput({name, "_wr_addr"}, WR_REQ_ADDR, 32'd0);
      checkOutput({name, "_rd_len"}, 32'(RD_REQ_LEN), 32'd0);
      checkOutput({name, "_wr_len"}, 32'(WR_REQ_LEN), 32'd0);
      checkOutput({name, "_status_err"}, 32'(STATUS_ERR), 32'd0);
   endtask

   // Monitor: a handshake seen at the falling edge completes at the next rising edge.
   initial begin
      burst_t b;
      forever begin
         @(negedge ACLK);
         if (ARESETN === 1'b1) begin
            if (RD_REQ_VALID && RD_REQ_READY) begin
               rd_count++;
               checkOutput("rd_burst_expected", 32'(exp_rd_q.size() != 0), 32'd1);
               if (exp_rd_q.size() != 0) begin
                  b = exp_rd_q.pop_front();
                  checkOutput("rd_addr", RD_REQ_ADDR, b.addr);
                  checkOutput("rd_len", 32'(RD_REQ_LEN), 32'(b.len));
               end
               checkOutput("rd_4k_cross", crosses_4k(RD_REQ_ADDR, RD_REQ_LEN), 32'd0);
            end
            if (WR_REQ_VALID && WR_REQ_READY) begin
               wr_count++;
               pending++;
               checkOutput("wr_burst_expected", 32'(exp_wr_q.size() != 0), 32'd1);
               if (exp_wr_q.size() != 0) begin
                  b = exp_wr_q.pop_front();
                  checkOutput("wr_addr", WR_REQ_ADDR, b.addr);
                  checkOutput("wr_len", 32'(WR_REQ_LEN), 32'(b.len));
               end
               checkOutput("wr_4k_cross", crosses_4k(WR_REQ_ADDR, WR_REQ_LEN), 32'd0);
            end
            if (WR_DONE)
               done_count++;
         end
      end
   end

   // Request-channel ready driver.
   initial begin
      RD_REQ_READY = 1'b0;
      WR_REQ_READY = 1'b0;
      forever begin
         @(posedge ACLK);
         #1;
         if (rand_ready) begin
            RD_REQ_READY = 1'($urandom_range(0, 1));
            WR_REQ_READY = 1'($urandom_range(0, 1));
         end else begin
            RD_REQ_READY = rd_ready_cfg;
            WR_REQ_READY = wr_ready_cfg;
         end
      end
   end

   // Write-completion responder: random latency, or one pulse per manual request.
   initial begin
      WR_DONE = 1'b0;
      WR_RESP = 2'b00;
      forever begin
         @(posedge ACLK);
         #1;
         WR_DONE = 1'b0;
         WR_RESP = 2'b00;
         if (ARESETN === 1'b1 && pending > 0) begin
            if (auto_done ? ($urandom_range(0, 2) == 0) : (manual_req > 0)) begin
               WR_DONE = 1'b1;
               pending--;
               if (!auto_done)
                  manual_req--;
               if (bad_once) begin
                  WR_RESP  = 2'b10;
                  bad_once = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      vecs[0] = '{cmd: 32'h1, src: 32'h0000_0100, dest: 32'h0000_5000, len: 32'd512, pairs: 4};
      vecs[1] = '{cmd: 32'h1, src: 32'h0000_1FC8, dest: 32'h2000_0000, len: 32'd200, pairs: 3};
      vecs[2] = '{cmd: 32'h1, src: 32'h0000_1003, dest: 32'h0000_2005, len: 32'd100, pairs: 1};
      vecs[3] = '{cmd: 32'h1, src: 32'h0000_0000, dest: 32'h0000_0FF8, len: 32'd40,  pairs: 2};
      vecs[4] = '{cmd: 32'h1, src: 32'hFFFF_FFC0, dest: 32'h0000_0100, len: 32'd128, pairs: 2};
      vecs[5] = '{cmd: 32'h0, src: 32'h0000_1000, dest: 32'h0000_2000, len: 32'd64,  pairs: 0};
      vecs[6] = '{cmd: 32'h1, src: 32'h0000_1000, dest: 32'h0000_2000, len: 32'd7,   pairs: 0};
      vecs[7] = '{cmd: 32'hFFFF_FFFE, src: 32'h0000_1000, dest: 32'h0000_2000, len: 32'd64, pairs: 0};

      abort        = 1'b0;
      ARESETN      = 1'b0;
      CONFIG_VALID = 1'b0;
      CONFIG_CMD   = '0;
      CONFIG_SRC   = '0;
      CONFIG_DEST  = '0;
      CONFIG_LEN   = '0;
      #12;
      check_reset_state("por");
      #10;
      ARESETN = 1'b1;

      // Two full-size bursts on 128-byte steps.
      push_pair(32'h1000, 32'h2000, 8'd15);
      push_pair(32'h1080, 32'h2080, 8'd15);
      applyStimulus(32'h1, 32'h1000, 32'h2000, 32'd256, 1'b0);
      checkOutput("plan1_err_after_accept", 32'(err_at_accept), 32'd0);
      wait_done("plan1", 2, 1'b0, 4, 5000);

      // Source starts 16 bytes below a 4 KB page.
      push_pair(32'h0FF0, 32'h3000, 8'd1);
      push_pair(32'h1000, 32'h3010, 8'd5);
      applyStimulus(32'h1, 32'h0FF0, 32'h3000, 32'd64, 1'b0);
      wait_done("plan2", 2, 1'b0, 4, 5000);

      rand_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].cmd, vecs[i].src, vecs[i].dest, vecs[i].len, 1'b1);
         if (vecs[i].pairs == 0)
            wait_done($sformatf("vec%0d", i), 0, 1'b0, 1, 1);
         else
            wait_done($sformatf("vec%0d", i), vecs[i].pairs, 1'b0, 4, 5000);
      end
      rand_ready = 1'b0;

      // Withhold completions: writes stop at MAX_OUTST, one completion frees one slot.
      auto_done = 1'b0;
      applyStimulus(32'h1, 32'h4000, 32'h8000, 32'd2048, 1'b1);
      repeat (60) @(posedge ACLK);
      @(negedge ACLK);
      checkOutput("outst_wr_count", 32'(wr_count), 32'd8);
      checkOutput("outst_rd_count", 32'(rd_count), 32'd9);
      checkOutput("outst_wr_valid_held", 32'(WR_REQ_VALID), 32'd0);
      manual_req = 1;
      repeat (10) @(posedge ACLK);
      @(negedge ACLK);
      checkOutput("outst_wr_count_after_done", 32'(wr_count), 32'd9);
      checkOutput("outst_wr_valid_held_again", 32'(WR_REQ_VALID), 32'd0);
      auto_done = 1'b1;
      wait_done("outst", 16, 1'b0, 4, 5000);

      // Error response is sticky until the next accept.
      bad_once = 1'b1;
      applyStimulus(32'h1, 32'h6000, 32'h7000, 32'd256, 1'b1);
      wait_done("bad_resp", 2, 1'b1, 4, 5000);
      applyStimulus(32'h1, 32'h6100, 32'h7100, 32'd128, 1'b1);
      checkOutput("err_cleared_on_accept", 32'(err_at_accept), 32'd0);
      wait_done("after_bad_resp", 1, 1'b0, 4, 5000);

      // Reset in the middle of issuing with three writes outstanding.
      auto_done = 1'b0;
      applyStimulus(32'h1, 32'h9000, 32'hA000, 32'd2048, 1'b1);
      guard = 0;
      while (wr_count < 3 && guard < 200) begin
         @(posedge ACLK);
         #1;
         guard++;
      end
      wr_ready_cfg = 1'b0;
      checkOutput("rst_setup_wr_count", 32'(wr_count), 32'd3);
      repeat (3) @(posedge ACLK);
      #3;
      checkOutput("rst_setup_wr_valid", 32'(WR_REQ_VALID), 32'd1);
      ARESETN = 1'b0;
      #1;
      check_reset_state("mid_reset");
      exp_rd_q.delete();
      exp_wr_q.delete();
      pending    = 0;
      manual_req = 0;
      @(posedge ACLK);
      #3;
      ARESETN      = 1'b1;
      wr_ready_cfg = 1'b1;
      auto_done    = 1'b1;
      applyStimulus(32'h1, 32'h0100, 32'h0200, 32'd64, 1'b1);
      wait_done("after_reset", 1, 1'b0, 4, 5000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
